maze_query_arbiter: RTL and testbench
=====================================

// Module: maze_query_arbiter
// PURPOSE
//  Shares the single maze wall-lookup port (tile map, 28x29 tiles, 16px tiles) between Pac-Man and the four ghosts.
//  Each mover posts a tile (x,y) query. The arbiter picks one requester round-robin and drives the maze ROM.
//  It returns the wall bit with a one-hot response strobe. Sits between the movement FSMs and the maze ROM.
// PARAMETERS
//  N_REQ     5   number of requesters (0=Pac-Man, 1..4=ghosts)
//  MAZE_W    28  tile columns; x >= MAZE_W is out of range
//  MAZE_H    29  tile rows; y >= MAZE_H is out of range
//  TB        5   tile-coordinate width in bits
// PORTS
//  Clk        in   1            system clock
//  Reset      in   1            asynchronous, active-high reset
//  req        in   N_REQ        per-requester query request, level
//  req_x      in   N_REQ x TB   per-requester tile column, held while req=1
//  req_y      in   N_REQ x TB   per-requester tile row, held while req=1
//  gnt        out  N_REQ        one-hot owner of the in-flight query (ISSUE..RESP)
//  rsp_valid  out  N_REQ        one-hot 1-cycle response strobe
//  rsp_wall   out  1            wall bit; valid when any rsp_valid bit is 1
//  maze_rd    out  1            ROM read enable
//  maze_x     out  TB           ROM tile column
//  maze_y     out  TB           ROM tile row
//  maze_wall  in   1            ROM data; registered ROM, valid 1 cycle after maze_rd
// BEHAVIOUR
//  Reset values: state=IDLE; gnt, rsp_valid, rsp_wall, maze_rd, maze_x, maze_y all 0; rr_ptr=N_REQ-1.
//  FSM states and transitions:
//   - IDLE:  if any req, register sel = first set req scanning rr_ptr+1, rr_ptr+2, ... (mod N_REQ);
//            latch req_x[sel] and req_y[sel]; go to ISSUE. Otherwise stay in IDLE.
//   - ISSUE: drive maze_x/maze_y from the latched coords. maze_rd=1 only if x<MAZE_W and y<MAZE_H. Go to WAIT.
//   - WAIT:  rsp_wall <= in range ? maze_wall : 0. Go to RESP.
//   - RESP:  rsp_valid[sel]=1; rr_ptr <= sel; go to IDLE.
//  Timing:
//   - Latency: req seen in IDLE at cycle t gives rsp_valid at t+3, for in-range and out-of-range queries alike.
//   - Throughput: one query per 4 cycles.
//   - gnt[sel]=1 in ISSUE, WAIT and RESP; 0 otherwise.
//  Handshake:
//   - The requester holds req and its coords until it sees rsp_valid.
//   - It deasserts req in the next cycle. A req still high in that cycle is a new query.
//   - Coords are latched in IDLE, so changes after the grant do not affect the query in flight.
//   - req dropping mid-query does not abort it; rsp_valid still pulses.
//  Boundaries:
//   - Out-of-range tile: the ROM is not read and rsp_wall=0, matching the draw path.
//   - Simultaneous requests: round-robin. After reset, requester 0 wins first.
//   - A requester served last has lowest priority next.
//   - maze_x/maze_y hold their last value outside ISSUE.
//   - Reset asserted mid-query: the query is dropped with no rsp_valid; all state returns to reset values.
// CONFIGURATION
//  Macro MAZE_ARB_STATS_EN.
//  - Defined: adds output q_count[15:0]. It counts completed queries (increments in RESP).
//    The count saturates at 16'hFFFF and resets to 0.
//  - Not defined: the port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package maze_pkg holds:
//   - MAZE_W, MAZE_H, TB and N_REQ constants;
//   - tile_coord_t (logic [TB-1:0]);
//   - requester index enum (REQ_PACMAN, REQ_BLINKY, REQ_PINKY, REQ_INKY, REQ_CLYDE);
//   - arb_state_t (IDLE, ISSUE, WAIT, RESP).
//  One sub-module, rr_pick: combinational round-robin picker. Inputs req[N_REQ] and rr_ptr; outputs sel index and any_req.
//  The arbiter FSM, coordinate latch and response registers stay in maze_query_arbiter.
// TESTING
//  1. Reset, req=5'b00001, (x,y)=(1,3), ROM wall=1 -> maze_rd at t+1 with (1,3); rsp_valid=5'b00001, rsp_wall=1 at t+3.
//  2. req=5'b11111 held, each requester drops req after its strobe -> grant order 0,1,2,3,4; strobes 4 cycles apart.
//  3. rr_ptr=2, req=5'b01101 -> order 3, then 0, then 2; no requester served twice while another waits.
//  4. req[1] with (28,5), then (5,29) -> maze_rd stays 0; rsp_valid[1] at t+3 with rsp_wall=0.
//  5. Reset pulsed during WAIT -> no rsp_valid; outputs 0 the next cycle; req=5'b00010 then served at t+3.
//  6. With MAZE_ARB_STATS_EN: 10 queries -> q_count=10; force count to 16'hFFFE, run 3 queries -> q_count=16'hFFFF.

Source files
------------

// File: rtl/maze_query_arbiter_pkg.sv
// Shared constants and types for the maze wall-lookup arbiter.
// The optional query counter is enabled by defining MAZE_ARB_STATS_EN.
package maze_pkg;

   localparam int N_REQ  = 5;
   localparam int MAZE_W = 28;
   localparam int MAZE_H = 29;
   localparam int TB     = 5;
   localparam int IDX_W  = $clog2(N_REQ);

   typedef logic [TB-1:0] tile_coord_t;

   typedef enum logic [IDX_W-1:0] {
      REQ_PACMAN,
      REQ_BLINKY,
      REQ_PINKY,
      REQ_INKY,
      REQ_CLYDE
   } req_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   function automatic logic tileInRange(input tile_coord_t x, input tile_coord_t y);
      return (x < TB'(MAZE_W)) && (y < TB'(MAZE_H));
   endfunction

   function automatic logic [N_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/maze_query_arbiter_if.sv
// Requester, response and maze-ROM signals of the wall-lookup arbiter.
// The slave modport is the arbiter; the master modport is the movers plus the ROM.
interface maze_query_arbiter_if;
   import maze_pkg::*;

   logic        [N_REQ-1:0] req;
   tile_coord_t [N_REQ-1:0] req_x;
   tile_coord_t [N_REQ-1:0] req_y;
   logic        [N_REQ-1:0] gnt;
   logic        [N_REQ-1:0] rsp_valid;
   logic                    rsp_wall;
   logic                    maze_rd;
   tile_coord_t             maze_x;
   tile_coord_t             maze_y;
   logic                    maze_wall;

   modport slave (
      input  req, req_x, req_y, maze_wall,
      output gnt, rsp_valid, rsp_wall, maze_rd, maze_x, maze_y
   );

   modport master (
      output req, req_x, req_y, maze_wall,
      input  gnt, rsp_valid, rsp_wall, maze_rd, maze_x, maze_y
   );

endinterface

// File: rtl/maze_query_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after rrPtr_i, wrapping.
module rr_pick
   import maze_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] rrPtr_i,
   output logic [IDX_W-1:0] sel_o,
   output logic             anyReq_o
);

   // Scan rrPtr_i+1 .. rrPtr_i+N_REQ so the last winner is checked last.
   always_comb begin
      logic [IDX_W:0] cand;
      sel_o    = '0;
      anyReq_o = 1'b0;
      cand     = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = {1'b0, rrPtr_i} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N_REQ)) begin
            cand = cand - (IDX_W+1)'(N_REQ);
         end
         if (!anyReq_o && req_i[cand[IDX_W-1:0]]) begin
            sel_o    = cand[IDX_W-1:0];
            anyReq_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/maze_query_arbiter.sv
// Shares the maze wall-lookup ROM between Pac-Man and the four ghosts (round-robin).
// Defining MAZE_ARB_STATS_EN adds the saturating completed-query counter q_count.
module maze_query_arbiter
   import maze_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   maze_query_arbiter_if.slave  bus
`ifdef MAZE_ARB_STATS_EN
   ,
   output logic [15:0]          q_count
`endif
);

   arb_state_t        state_q;
   req_idx_t          sel_q;
   req_idx_t          rrPtr_q;
   logic              inRange_q;
   logic [N_REQ-1:0]  gnt_q;
   logic [N_REQ-1:0]  rspValid_q;
   logic              rspWall_q;
   logic              mazeRd_q;
   tile_coord_t       mazeX_q;
   tile_coord_t       mazeY_q;

   logic [IDX_W-1:0]  pickSel;
   logic              pickAny;
   logic              pickInRange;

   rr_pick uPick (
      .req_i    (bus.req),
      .rrPtr_i  (rrPtr_q),
      .sel_o    (pickSel),
      .anyReq_o (pickAny)
   );

   assign pickInRange = tileInRange(bus.req_x[pickSel], bus.req_y[pickSel]);

   // Every output is registered on the edge entering the state that owns it,
   // so the ROM address doubles as the coordinate latch.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         sel_q      <= REQ_PACMAN;
         rrPtr_q    <= REQ_CLYDE;
         inRange_q  <= 1'b0;
         gnt_q      <= '0;
         rspValid_q <= '0;
         rspWall_q  <= 1'b0;
         mazeRd_q   <= 1'b0;
         mazeX_q    <= '0;
         mazeY_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pickAny) begin
                  sel_q     <= req_idx_t'(pickSel);
                  mazeX_q   <= bus.req_x[pickSel];
                  mazeY_q   <= bus.req_y[pickSel];
                  inRange_q <= pickInRange;
                  mazeRd_q  <= pickInRange;
                  gnt_q     <= oneHot(pickSel);
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               mazeRd_q <= 1'b0;
               state_q  <= WAIT;
            end
            WAIT: begin
               // Off-map tiles report open space, matching the draw path.
               rspWall_q  <= inRange_q ? bus.maze_wall : 1'b0;
               rspValid_q <= oneHot(sel_q);
               state_q    <= RESP;
            end
            RESP: begin
               rspValid_q <= '0;
               gnt_q      <= '0;
               rrPtr_q    <= sel_q;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_wall  = rspWall_q;
   assign bus.maze_rd   = mazeRd_q;
   assign bus.maze_x    = mazeX_q;
   assign bus.maze_y    = mazeY_q;

`ifdef MAZE_ARB_STATS_EN
   logic [15:0] qCount_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         qCount_q <= '0;
      end else if (state_q == RESP && qCount_q != 16'hFFFF) begin
         qCount_q <= qCount_q + 16'd1;
      end
   end

   assign q_count = qCount_q;
`endif

endmodule

// File: tb/tb_maze_query_arbiter.sv
// Self-checking bench for maze_query_arbiter: vector table plus round-robin and reset sequences.
module tb_maze_query_arbiter;
   import maze_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic romWall = 1'b0;
   int   passCount = 0;
   int   checkCount = 0;
   int   cycle = 0;
   int   expOrder[5];
`ifdef MAZE_ARB_STATS_EN
   logic [15:0] qCount;
`endif

   maze_query_arbiter_if bus();

   maze_query_arbiter dut (
      .Clk   (clock),
      .Reset (reset),
      .bus   (bus)
`ifdef MAZE_ARB_STATS_EN
      ,
      .q_count (qCount)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   // Registered ROM: data appears one cycle after a read and holds otherwise.
   always @(posedge clock or posedge reset) begin
      if (reset) bus.maze_wall <= 1'b0;
      else if (bus.maze_rd) bus.maze_wall <= romWall;
   end

   typedef struct {
      logic [N_REQ-1:0] req;
      int               idx;
      tile_coord_t      x;
      tile_coord_t      y;
      logic             wall;
      logic             dropEarly;
      logic             expRd;
      logic             expWall;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic setCoords();
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_x[i] = TB'(i + 9);
         bus.req_y[i] = TB'(i + 11);
      end
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      bus.req = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      tick();
      setCoords();
      bus.req_x[v.idx] = v.x;
      bus.req_y[v.idx] = v.y;
      romWall = v.wall;
      bus.req = v.req;
      tick();
      checkOutput("issue maze_rd", 32'(bus.maze_rd), 32'(v.expRd));
      checkOutput("issue maze_x", 32'(bus.maze_x), 32'(v.x));
      checkOutput("issue maze_y", 32'(bus.maze_y), 32'(v.y));
      checkOutput("issue gnt", 32'(bus.gnt), 32'(v.req));
      bus.req_x[v.idx] = ~v.x;
      if (v.dropEarly) bus.req = '0;
      tick();
      checkOutput("wait rsp_valid", 32'(bus.rsp_valid), 32'(0));
      checkOutput("wait maze_rd", 32'(bus.maze_rd), 32'(0));
      tick();
      checkOutput("resp rsp_valid", 32'(bus.rsp_valid), 32'(v.req));
      checkOutput("resp rsp_wall", 32'(bus.rsp_wall), 32'(v.expWall));
      bus.req = '0;
      tick();
      checkOutput("idle rsp_valid", 32'(bus.rsp_valid), 32'(0));
      checkOutput("idle gnt", 32'(bus.gnt), 32'(0));
   endtask

   task automatic runRound(input int n, input string tag);
      int lastCycle;
      int found;
      logic [N_REQ-1:0] seen;
      lastCycle = 0;
      for (int k = 0; k < n; k++) begin
         found = 0;
         for (int w = 0; w < 12 && found == 0; w++) begin
            tick();
            if (|bus.rsp_valid) found = 1;
         end
         checkOutput({tag, " strobe within budget"}, 32'(found), 32'(1));
         if (found == 0) break;
         seen = bus.rsp_valid;
         checkOutput({tag, " grant order"}, 32'(seen), 32'(1) << expOrder[k]);
         checkOutput({tag, " gnt matches strobe"}, 32'(bus.gnt), 32'(seen));
         if (k > 0) checkOutput({tag, " strobe spacing"}, 32'(cycle - lastCycle), 32'(4));
         lastCycle = cycle;
         bus.req = bus.req & ~seen;
      end
      bus.req = '0;
      tick();
   endtask

   initial begin
      int strays;
      vec_t v;

      vecs[0] = '{5'b00001, 0, 5'd1,  5'd3,  1'b1, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{5'b00100, 2, 5'd27, 5'd28, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{5'b01000, 3, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{5'b00010, 1, 5'd28, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{5'b00010, 1, 5'd5,  5'd29, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{5'b10000, 4, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{5'b10000, 4, 5'd27, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1};

      bus.req = '0;
      setCoords();
      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset gnt", 32'(bus.gnt), 32'(0));
      checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'(0));
      checkOutput("reset rsp_wall", 32'(bus.rsp_wall), 32'(0));
      checkOutput("reset maze_rd", 32'(bus.maze_rd), 32'(0));
      checkOutput("reset maze_x", 32'(bus.maze_x), 32'(0));
      checkOutput("reset maze_y", 32'(bus.maze_y), 32'(0));

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      $display("[TB] all five requesting after reset");
      pulseReset();
      setCoords();
      romWall = 1'b0;
      bus.req = 5'b11111;
      expOrder = '{0, 1, 2, 3, 4};
      runRound(5, "rr all");

      $display("[TB] rr_ptr=2 with req=01101");
      v = '{5'b00100, 2, 5'd2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      applyStimulus(v);
      bus.req = 5'b01101;
      expOrder = '{3, 0, 2, 0, 0};
      runRound(3, "rr partial");

      $display("[TB] reset during WAIT");
      tick();
      setCoords();
      romWall = 1'b1;
      bus.req = 5'b00001;
      tick();
      tick();
      reset = 1'b1;
      bus.req = '0;
      tick();
      reset = 1'b0;
      checkOutput("midreset gnt", 32'(bus.gnt), 32'(0));
      checkOutput("midreset rsp_valid", 32'(bus.rsp_valid), 32'(0));
      checkOutput("midreset maze_x", 32'(bus.maze_x), 32'(0));
      checkOutput("midreset maze_y", 32'(bus.maze_y), 32'(0));
      strays = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (|bus.rsp_valid) strays++;
      end
      checkOutput("midreset stray strobes", 32'(strays), 32'(0));
      v = '{5'b00010, 1, 5'd4, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1};
      applyStimulus(v);

`ifdef MAZE_ARB_STATS_EN
      $display("[TB] query counter");
      pulseReset();
      checkOutput("q_count reset", 32'(qCount), 32'(0));
      v = '{5'b00001, 0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 10; i++) applyStimulus(v);
      checkOutput("q_count ten", 32'(qCount), 32'(10));
      force dut.qCount_q = 16'hFFFE;
      tick();
      release dut.qCount_q;
      for (int i = 0; i < 3; i++) applyStimulus(v);
      checkOutput("q_count saturate", 32'(qCount), 32'hFFFF);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
